spi_frame_rx: RTL

- Parametrised SPI slave front-end for the branch predictor. Generalises the single-address/single-direction receiver.
- Receives frames of ADDR_WIDTH instruction-address bits followed by DIR_BITS ground-truth direction bits. Validates frame length and publishes a one-cycle frame_valid strobe to the predictor core.
- Shifts the core's current prediction back to the host on miso during the same frame. Counts malformed frames.

---
 rtl/spi_frame_rx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/spi_frame_rx.sv
// SPI slave front-end for the branch predictor: receives address+direction frames,
// validates their length, and returns the core's prediction on miso.
module spi_frame_rx #(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DIR_BITS      = 1,
  parameter int unsigned SAMPLE_EDGE   = 0,
  parameter int unsigned PRED_BITS     = 2,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cs,
  input  logic                     sclk,
  input  logic                     mosi,
  output logic                     miso,
  input  logic [PRED_BITS-1:0]     pred_in,
  output logic [ADDR_WIDTH-1:0]    inst_addr,
  output logic [DIR_BITS-1:0]      direction,
  output logic                     frame_valid,
  output logic                     frame_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int unsigned FRAME_BITS = ADDR_WIDTH + DIR_BITS;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, CHECK} state_t;

  state_t state, state_nxt;

  logic [2:0] cs_sync;
  logic [2:0] sclk_sync;
  logic [1:0] mosi_sync;

  logic [FRAME_BITS-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [PRED_BITS-1:0]  pred_sr;

  logic cs_s, cs_rise, sclk_rise, sclk_fall, mosi_s;
  logic sample_edge, shift_edge;
  logic start, sample, shift_out, finish, check, cnt_ok;

  // Synchronisers are left unreset; they settle within the reset pulse.
  always_ff @(posedge clk) begin
    cs_sync   <= {cs_sync[1:0], cs};
    sclk_sync <= {sclk_sync[1:0], sclk};
    mosi_sync <= {mosi_sync[0], mosi};
  end

  assign cs_s      = cs_sync[1];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign mosi_s    = mosi_sync[1];

  assign sample_edge = (SAMPLE_EDGE == 0) ? sclk_rise : sclk_fall;
  assign shift_edge  = (SAMPLE_EDGE == 0) ? sclk_fall : sclk_rise;

  assign cnt_ok = (bit_cnt == CNT_FULL);
  assign miso   = pred_sr[PRED_BITS-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WAIT_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // IDLE starts on cs level rather than edge so a fall landing in CHECK is kept.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    sample    = 1'b0;
    shift_out = 1'b0;
    finish    = 1'b0;
    check     = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (cs_s) state_nxt = IDLE;
      end
      IDLE: begin
        if (!cs_s) begin
          state_nxt = SHIFT;
          start     = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nxt = CHECK;
          finish    = 1'b1;
        end else begin
          sample    = sample_edge;
          shift_out = shift_edge;
        end
      end
      CHECK: begin
        state_nxt = IDLE;
        check     = 1'b1;
      end
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      pred_sr     <= '0;
      inst_addr   <= '0;
      direction   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
    end else begin
      frame_valid <= check & cnt_ok;
      frame_err   <= check & ~cnt_ok;

      if (start) begin
        pred_sr <= pred_in;
        bit_cnt <= '0;
      end

      if (sample) begin
        shreg <= {shreg[FRAME_BITS-2:0], mosi_s};
        if (bit_cnt != CNT_OVR) bit_cnt <= bit_cnt + 1'b1;
      end

      if (shift_out) pred_sr <= pred_sr << 1;
      if (finish)    pred_sr <= '0;

      if (check) begin
        if (cnt_ok) begin
          inst_addr <= shreg[FRAME_BITS-1:DIR_BITS];
          direction <= shreg[DIR_BITS-1:0];
        end else if (err_count != '1) begin
          err_count <= err_count + 1'b1;
        end
      end
    end
  end

endmodule
